// File: rtl/axis_packet_pkg.sv
// Shared framing constants, FSM state encoding and result payload for the AXIS packet parser.
package axis_packet_pkg;

    localparam logic [31:0] HEADER_VALUE = 32'hAAAA_AAAA;
    localparam logic [31:0] FOOTER_VALUE = 32'h5555_5555;
    localparam logic [31:0] TLAST_VALUE  = 32'hBBBB_BBBB;

    localparam int unsigned PROC_WORDS = 3;
    localparam int unsigned IDX_W      = 9;
    localparam int unsigned ACC_W      = 48;

    typedef enum logic [3:0] {
        ST_HUNT       = 4'd0,
        ST_TIME_STAMP = 4'd1,
        ST_PAYLOAD    = 4'd2,
        ST_FOOTER     = 4'd3,
        ST_POST       = 4'd4
    } state_e;

    typedef struct packed {
        logic [31:0]      ts;
        logic [ACC_W-1:0] d_acc;
        logic [ACC_W-1:0] c_acc;
    } result_t;

endpackage

// File: rtl/axis_pkt_err_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module axis_pkt_err_counter
    import axis_packet_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count up on inc_i, holding at all-ones.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/axis_packet_parser.sv
// Receive-side AXIS framing checker: HEADER, timestamp, payload, FOOTER, optional BBBBBBBB tlast.
// Optional build macro TIMESTAMP_CHECK_EN adds a monotonic-timestamp check and the ts_error port.
module axis_packet_parser
    import axis_packet_pkg::*;
#(
    parameter int unsigned RAW_WORDS      = 512,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             master_clock,
    input  logic             reset,
    input  logic             send_raw_data,
    input  logic [31:0]      data_tdata,
    input  logic             data_tvalid,
    input  logic             data_tlast,
    output logic             data_tready,
    output logic [31:0]      raw_word,
    output logic [IDX_W-1:0] raw_index,
    output logic             raw_valid,
    output logic [31:0]      res_timestamp,
    output logic [ACC_W-1:0] res_c_acc,
    output logic [ACC_W-1:0] res_d_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             burst_done,
    output logic [CNT_W-1:0] packet_count,
    output logic [CNT_W-1:0] error_count,
    output logic [3:0]       dbg_state
`ifdef TIMESTAMP_CHECK_EN
    ,
    output logic             ts_error
`endif
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] beat_q, beat_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [31:0]      ts_stage_q, ts_stage_d;
    logic [ACC_W-1:0] c_stage_q, c_stage_d;
    logic [ACC_W-1:0] d_stage_q, d_stage_d;
    result_t          res_q, res_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      raw_word_q, raw_word_d;
    logic [IDX_W-1:0] raw_index_q, raw_index_d;
    logic             raw_valid_q, raw_valid_d;
    logic             burst_done_q, burst_done_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             err_inc;
    logic             accept;
    logic             timeout_hit;
`ifdef TIMESTAMP_CHECK_EN
    logic [31:0]      prev_ts_q, prev_ts_d;
    logic             have_prev_q, have_prev_d;
    logic             ts_error_q, ts_error_d;
`endif

    // Stall the stream only while an unconsumed result is pending.
    assign data_tready = !(res_valid_q && !res_ready);
    assign accept      = data_tvalid && data_tready;
    assign timeout_hit = !accept && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        beat_d       = beat_q;
        idle_d       = '0;
        ts_stage_d   = ts_stage_q;
        c_stage_d    = c_stage_q;
        d_stage_d    = d_stage_q;
        res_d        = res_q;
        res_valid_d  = res_valid_q && !res_ready;
        raw_word_d   = raw_word_q;
        raw_index_d  = raw_index_q;
        raw_valid_d  = 1'b0;
        burst_done_d = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        err_inc      = 1'b0;
`ifdef TIMESTAMP_CHECK_EN
        prev_ts_d    = prev_ts_q;
        have_prev_d  = have_prev_q;
        ts_error_d   = ts_error_q;
`endif

        // Idle watchdog for the in-packet states.
        if ((state_q == ST_TIME_STAMP) || (state_q == ST_PAYLOAD) || (state_q == ST_FOOTER)) begin
            if (timeout_hit) begin
                err_inc = 1'b1;
                state_d = ST_HUNT;
            end else if (!accept) begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        case (state_q)
            ST_HUNT: begin
                if (accept && (data_tdata == HEADER_VALUE)) begin
                    mode_d  = send_raw_data;
                    state_d = ST_TIME_STAMP;
                end
            end
            ST_TIME_STAMP: begin
                if (accept) begin
                    if (data_tlast) begin
                        err_inc = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        ts_stage_d = data_tdata;
                        beat_d     = '0;
                        state_d    = ST_PAYLOAD;
`ifdef TIMESTAMP_CHECK_EN
                        if (have_prev_q && !(data_tdata > prev_ts_q)) begin
                            err_inc    = 1'b1;
                            ts_error_d = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    if (data_tlast) begin
                        err_inc = 1'b1;
                        state_d = ST_HUNT;
                    end else if (mode_q) begin
                        raw_valid_d = 1'b1;
                        raw_word_d  = data_tdata;
                        raw_index_d = beat_q;
                        beat_d      = beat_q + IDX_W'(1);
                        if (beat_q == IDX_W'(RAW_WORDS - 1)) begin
                            state_d = ST_FOOTER;
                        end
                    end else begin
                        // Processed payload is {d_acc, c_acc}, least-significant word first.
                        case (beat_q)
                            IDX_W'(0): c_stage_d[31:0] = data_tdata;
                            IDX_W'(1): begin
                                c_stage_d[47:32] = data_tdata[15:0];
                                d_stage_d[15:0]  = data_tdata[31:16];
                            end
                            default:   d_stage_d[47:16] = data_tdata;
                        endcase
                        beat_d = beat_q + IDX_W'(1);
                        if (beat_q == IDX_W'(PROC_WORDS - 1)) begin
                            state_d = ST_FOOTER;
                        end
                    end
                end
            end
            ST_FOOTER: begin
                if (accept) begin
                    if (data_tdata == FOOTER_VALUE) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        if (!mode_q) begin
                            res_d.ts    = ts_stage_q;
                            res_d.c_acc = c_stage_q;
                            res_d.d_acc = d_stage_q;
                            res_valid_d = 1'b1;
                        end
`ifdef TIMESTAMP_CHECK_EN
                        prev_ts_d   = ts_stage_q;
                        have_prev_d = 1'b1;
`endif
                        state_d = ST_POST;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_POST: begin
                if (accept) begin
                    if (data_tdata == HEADER_VALUE) begin
                        mode_d  = send_raw_data;
                        state_d = ST_TIME_STAMP;
                    end else if ((data_tdata == TLAST_VALUE) && data_tlast) begin
                        burst_done_d = 1'b1;
                        state_d      = ST_HUNT;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            mode_q       <= 1'b0;
            beat_q       <= '0;
            idle_q       <= '0;
            ts_stage_q   <= '0;
            c_stage_q    <= '0;
            d_stage_q    <= '0;
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            raw_word_q   <= '0;
            raw_index_q  <= '0;
            raw_valid_q  <= 1'b0;
            burst_done_q <= 1'b0;
            pkt_cnt_q    <= '0;
`ifdef TIMESTAMP_CHECK_EN
            prev_ts_q    <= '0;
            have_prev_q  <= 1'b0;
            ts_error_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            beat_q       <= beat_d;
            idle_q       <= idle_d;
            ts_stage_q   <= ts_stage_d;
            c_stage_q    <= c_stage_d;
            d_stage_q    <= d_stage_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            raw_word_q   <= raw_word_d;
            raw_index_q  <= raw_index_d;
            raw_valid_q  <= raw_valid_d;
            burst_done_q <= burst_done_d;
            pkt_cnt_q    <= pkt_cnt_d;
`ifdef TIMESTAMP_CHECK_EN
            prev_ts_q    <= prev_ts_d;
            have_prev_q  <= have_prev_d;
            ts_error_q   <= ts_error_d;
`endif
        end
    end

    // Framing error counter; reset takes priority over a same-cycle error.
    axis_pkt_err_counter #(
        .W (CNT_W)
    ) u_err_counter (
        .clk_i   (master_clock),
        .clr_i   (reset),
        .inc_i   (err_inc),
        .count_o (error_count)
    );

    assign raw_word      = raw_word_q;
    assign raw_index     = raw_index_q;
    assign raw_valid     = raw_valid_q;
    assign res_timestamp = res_q.ts;
    assign res_c_acc     = res_q.c_acc;
    assign res_d_acc     = res_q.d_acc;
    assign res_valid     = res_valid_q;
    assign burst_done    = burst_done_q;
    assign packet_count  = pkt_cnt_q;
    assign dbg_state     = 4'(state_q);
`ifdef TIMESTAMP_CHECK_EN
    assign ts_error      = ts_error_q;
`endif

endmodule

// File: tb/tb_axis_packet_parser.sv
// Directed plus randomized bench for axis_packet_parser with a packet-level reference model.
module tb_axis_packet_parser;
    import axis_packet_pkg::*;

    localparam int unsigned RAW_WORDS      = 512;
    localparam int unsigned TIMEOUT_CYCLES = 4096;
    localparam int unsigned CNT_W          = 16;

    logic              master_clock = 1'b0;
    logic              reset = 1'b0;
    logic              send_raw_data = 1'b0;
    logic [31:0]       data_tdata = '0;
    logic              data_tvalid = 1'b0;
    logic              data_tlast = 1'b0;
    logic              data_tready;
    logic [31:0]       raw_word;
    logic [8:0]        raw_index;
    logic              raw_valid;
    logic [31:0]       res_timestamp;
    logic [47:0]       res_c_acc;
    logic [47:0]       res_d_acc;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic              burst_done;
    logic [CNT_W-1:0]  packet_count;
    logic [CNT_W-1:0]  error_count;
    logic [3:0]        dbg_state;
`ifdef TIMESTAMP_CHECK_EN
    logic              ts_error;
`endif

    axis_packet_parser #(
        .RAW_WORDS      (RAW_WORDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .master_clock  (master_clock),
        .reset         (reset),
        .send_raw_data (send_raw_data),
        .data_tdata    (data_tdata),
        .data_tvalid   (data_tvalid),
        .data_tlast    (data_tlast),
        .data_tready   (data_tready),
        .raw_word      (raw_word),
        .raw_index     (raw_index),
        .raw_valid     (raw_valid),
        .res_timestamp (res_timestamp),
        .res_c_acc     (res_c_acc),
        .res_d_acc     (res_d_acc),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .burst_done    (burst_done),
        .packet_count  (packet_count),
        .error_count   (error_count),
        .dbg_state     (dbg_state)
`ifdef TIMESTAMP_CHECK_EN
        ,
        .ts_error      (ts_error)
`endif
    );

    always #5 master_clock = ~master_clock;

    typedef struct packed {
        logic [8:0]  idx;
        logic [31:0] word;
    } strobe_t;

    strobe_t obs_q[$];
    int      burst_seen = 0;

    // Record raw strobes and burst pulses away from the active edge.
    always @(negedge master_clock) begin
        if (raw_valid) obs_q.push_back({raw_index, raw_word});
        if (burst_done) burst_seen++;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one beat from a negedge and return at the negedge after it is accepted.
    task automatic send(input logic [31:0] d, input logic l);
        int guard;
        data_tdata  = d;
        data_tlast  = l;
        data_tvalid = 1'b1;
        guard = 0;
        while (!data_tready && guard < 1000) begin
            @(negedge master_clock);
            guard++;
        end
        if (!data_tready) begin
            n_total++;
            $error("FAIL send_stall: observed tready 0 expected 1");
        end
        @(negedge master_clock);
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge master_clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic send_proc(input logic [31:0] ts, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2);
        send_raw_data = 1'b0;
        send(HEADER_VALUE, 1'b0);
        send(ts, 1'b0);
        send(w0, 1'b0);
        send(w1, 1'b0);
        send(w2, 1'b0);
        send(FOOTER_VALUE, 1'b0);
    endtask

    // Reference model state: counters, last processed result, expected raw strobes.
    strobe_t     exp_q[$];
    int          exp_pkt = 0;
    int          exp_err = 0;
    int          exp_burst = 0;
    logic [47:0] exp_c = '0;
    logic [47:0] exp_d = '0;
    logic [31:0] exp_ts = '0;

    function automatic int raw_mismatches();
        int bad = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= obs_q.size()) bad++;
            else if (obs_q[k] !== exp_q[k]) bad++;
        end
        return bad;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ts_next;
        logic        in_hunt;
        logic [31:0] w[3];
        logic [31:0] wd;
        int          raw, kind, trailer, k, gapn;

        @(negedge master_clock);
        do_reset();
        check("rst_tready", 64'(data_tready), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_pkt", 64'(packet_count), 64'd0);
        check("rst_err", 64'(error_count), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_outs", {res_c_acc, 16'(raw_valid) | 16'(burst_done)}, 64'd0);

        // Processed packet with backpressure on the trailing word.
        res_ready = 1'b0;
        send_proc(32'h10, 32'h89AB_CDEF, 32'h4567_0123, 32'h0011_2233);
        exp_pkt = 1;
        check("p1_res_valid", 64'(res_valid), 64'd1);
        check("p1_pkt", 64'(packet_count), 64'd1);
        check("p1_state_post", 64'(dbg_state), 64'd4);
        check("p1_tready_low", 64'(data_tready), 64'd0);
        data_tdata = TLAST_VALUE; data_tlast = 1'b1; data_tvalid = 1'b1;
        idle(4);
        check("bp_tready_low", 64'(data_tready), 64'd0);
        check("bp_state_hold", 64'(dbg_state), 64'd4);
        check("bp_res_hold", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        @(negedge master_clock);
        data_tvalid = 1'b0; data_tlast = 1'b0;
        check("p1_burst_pulse", 64'(burst_done), 64'd1);
        check("p1_res_cleared", 64'(res_valid), 64'd0);
        check("p1_state_hunt", 64'(dbg_state), 64'd0);
        @(negedge master_clock);
        check("p1_burst_one", 64'(burst_done), 64'd0);
        exp_burst = 1;
        check("p1_burst_cnt", 64'(burst_seen), 64'(exp_burst));
        check("p1_c_acc", 64'(res_c_acc), 64'h0123_89AB_CDEF);
        check("p1_d_acc", 64'(res_d_acc), 64'h0011_2233_4567);
        check("p1_ts", 64'(res_timestamp), 64'h10);
        exp_c = 48'h0123_89AB_CDEF; exp_d = 48'h0011_2233_4567; exp_ts = 32'h10;

        // Raw packet of RAW_WORDS beats with word i.
        send_raw_data = 1'b1;
        send(HEADER_VALUE, 1'b0);
        send(32'h20, 1'b0);
        for (int i = 0; i < RAW_WORDS; i++) begin
            send(32'(i), 1'b0);
            exp_q.push_back({9'(i), 32'(i)});
        end
        send(FOOTER_VALUE, 1'b0);
        send(TLAST_VALUE, 1'b1);
        exp_pkt++; exp_burst++;
        idle(2);
        check("raw_cnt", 64'(obs_q.size()), 64'(RAW_WORDS));
        check("raw_seq", 64'(raw_mismatches()), 64'd0);
        check("raw_pkt", 64'(packet_count), 64'(exp_pkt));
        check("raw_err", 64'(error_count), 64'd0);
        check("raw_res_untouched", 64'(res_timestamp), 64'h10);

        // Bad footer, then a good packet.
        send_raw_data = 1'b0;
        send(HEADER_VALUE, 1'b0);
        send(32'h30, 1'b0);
        send(32'h1, 1'b0); send(32'h2, 1'b0); send(32'h3, 1'b0);
        send(32'h1234_5678, 1'b0);
        exp_err++;
        check("badfoot_err", 64'(error_count), 64'd1);
        check("badfoot_state", 64'(dbg_state), 64'd0);
        send_proc(32'h40, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        send(TLAST_VALUE, 1'b1);
        exp_pkt++; exp_burst++;
        exp_c = 48'h2222_1111_1111; exp_d = 48'h3333_3333_2222; exp_ts = 32'h40;
        check("badfoot_next_pkt", 64'(packet_count), 64'(exp_pkt));
        check("badfoot_next_c", 64'(res_c_acc), 64'(exp_c));
        check("badfoot_next_d", 64'(res_d_acc), 64'(exp_d));

        // Idle timeout after the timestamp.
        send(HEADER_VALUE, 1'b0);
        send(32'h50, 1'b0);
        idle(TIMEOUT_CYCLES - 1);
        check("tmo_not_yet", 64'(dbg_state), 64'd2);
        check("tmo_err_not_yet", 64'(error_count), 64'd1);
        idle(1);
        exp_err++;
        check("tmo_state", 64'(dbg_state), 64'd0);
        check("tmo_err", 64'(error_count), 64'(exp_err));
        send(HEADER_VALUE, 1'b0);
        check("tmo_hdr_accepted", 64'(dbg_state), 64'd1);
        send(32'h60, 1'b0);
        send(32'h5, 1'b0); send(32'h6, 1'b0); send(32'h7, 1'b0);
        send(FOOTER_VALUE, 1'b0);
        send(TLAST_VALUE, 1'b1);
        exp_pkt++; exp_burst++;
        exp_c = {16'h0006, 32'h5}; exp_d = {32'h7, 16'h0000}; exp_ts = 32'h60;
        check("tmo_next_pkt", 64'(packet_count), 64'(exp_pkt));

        // tlast inside the payload aborts the packet.
        send(HEADER_VALUE, 1'b0);
        send(32'h70, 1'b0);
        send(32'h9, 1'b0);
        send(32'hA, 1'b1);
        exp_err++;
        check("midlast_err", 64'(error_count), 64'(exp_err));
        check("midlast_state", 64'(dbg_state), 64'd0);

        // Header value inside the payload is data, not a resync.
        send_proc(32'h80, 32'hDEAD_BEEF, HEADER_VALUE, 32'h0102_0304);
        send(TLAST_VALUE, 1'b1);
        exp_pkt++; exp_burst++;
        exp_c = 48'hAAAA_DEAD_BEEF; exp_d = 48'h0102_0304_AAAA; exp_ts = 32'h80;
        check("hdr_in_payload_c", 64'(res_c_acc), 64'(exp_c));
        check("hdr_in_payload_d", 64'(res_d_acc), 64'(exp_d));
        check("hdr_in_payload_pkt", 64'(packet_count), 64'(exp_pkt));

        // Randomized packet stream against the model.
        ts_next = 32'h1000;
        in_hunt = 1'b1;
        for (int p = 0; p < 16; p++) begin
            if (in_hunt && ($urandom_range(0, 1) == 1)) begin
                wd = $urandom;
                if (wd == HEADER_VALUE) wd = 32'h0;
                send(wd, 1'($urandom_range(0, 1)));
            end
            raw  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            kind = $urandom_range(0, 5);
            send_raw_data = 1'(raw);
            send(HEADER_VALUE, 1'b0);
            ts_next = ts_next + 32'($urandom_range(1, 100));
            send(ts_next, 1'b0);
            if (raw == 1) begin
                for (int i = 0; i < RAW_WORDS; i++) begin
                    wd = $urandom;
                    send(wd, 1'b0);
                    exp_q.push_back({9'(i), wd});
                    if ($urandom_range(0, 7) == 0) idle(1);
                end
            end else begin
                for (int i = 0; i < 3; i++) w[i] = $urandom;
                if (kind == 1) begin
                    k = $urandom_range(0, 2);
                    for (int i = 0; i < k; i++) send(w[i], 1'b0);
                    send(w[k], 1'b1);
                    exp_err++;
                    in_hunt = 1'b1;
                    idle(2);
                    check("rnd_abort_err", 64'(error_count), 64'(exp_err));
                    check("rnd_abort_pkt", 64'(packet_count), 64'(exp_pkt));
                    continue;
                end
                for (int i = 0; i < 3; i++) begin
                    send(w[i], 1'b0);
                    gapn = $urandom_range(0, 3);
                    idle(gapn);
                end
            end
            if (kind == 0) begin
                wd = $urandom;
                if (wd == FOOTER_VALUE) wd = 32'h0;
                send(wd, 1'b0);
                exp_err++;
                in_hunt = 1'b1;
            end else begin
                send(FOOTER_VALUE, 1'b0);
                exp_pkt++;
                if (raw == 0) begin
                    exp_c  = {w[1][15:0], w[0]};
                    exp_d  = {w[2], w[1][31:16]};
                    exp_ts = ts_next;
                end
                trailer = (p == 15) ? 0 : $urandom_range(0, 2);
                if (trailer == 0) begin
                    send(TLAST_VALUE, 1'b1);
                    exp_burst++;
                    in_hunt = 1'b1;
                end else if (trailer == 2) begin
                    send(TLAST_VALUE, 1'b0);
                    exp_err++;
                    in_hunt = 1'b1;
                end else begin
                    in_hunt = 1'b0;
                end
            end
            idle(2);
            check("rnd_pkt", 64'(packet_count), 64'(exp_pkt));
            check("rnd_err", 64'(error_count), 64'(exp_err));
        end
        idle(2);
        check("rnd_burst", 64'(burst_seen), 64'(exp_burst));
        check("rnd_c", 64'(res_c_acc), 64'(exp_c));
        check("rnd_d", 64'(res_d_acc), 64'(exp_d));
        check("rnd_ts", 64'(res_timestamp), 64'(exp_ts));
        check("rnd_raw_cnt", 64'(obs_q.size()), 64'(exp_q.size()));
        check("rnd_raw_seq", 64'(raw_mismatches()), 64'd0);

        // Reset mid-packet: counters clear and the tail is discarded silently.
        send_raw_data = 1'b0;
        send(HEADER_VALUE, 1'b0);
        send(32'hF000_0000, 1'b0);
        send(32'h1, 1'b0);
        do_reset();
        check("midrst_pkt", 64'(packet_count), 64'd0);
        check("midrst_err", 64'(error_count), 64'd0);
        check("midrst_res", 64'(res_c_acc), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
        exp_burst = burst_seen;
        send(32'h2, 1'b0);
        send(32'h3, 1'b0);
        send(FOOTER_VALUE, 1'b0);
        send(TLAST_VALUE, 1'b1);
        idle(2);
        check("tail_err", 64'(error_count), 64'd0);
        check("tail_pkt", 64'(packet_count), 64'd0);
        check("tail_burst", 64'(burst_seen), 64'(exp_burst));

`ifdef TIMESTAMP_CHECK_EN
        // Non-increasing timestamp is flagged but still reported.
        do_reset();
        send_proc(32'd20, 32'h1, 32'h2, 32'h3);
        send(TLAST_VALUE, 1'b1);
        check("ts_first_ok", 64'(ts_error), 64'd0);
        send_proc(32'd15, 32'h4, 32'h5, 32'h6);
        send(TLAST_VALUE, 1'b1);
        check("ts_err_cnt", 64'(error_count), 64'd1);
        check("ts_error_flag", 64'(ts_error), 64'd1);
        check("ts_pkt_cnt", 64'(packet_count), 64'd2);
        check("ts_reported", 64'(res_timestamp), 64'd15);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_packet_parser.md
Name: axis_packet_parser

Overview:
- Receive-side counterpart of the sensor acquisition packetiser.
- Consumes the 32-bit AXI-Stream burst on the PS/loopback side and checks the framing: header AAAAAAAA, timestamp, payload, footer 55555555, and a burst-terminating word BBBBBBBB that carries tlast.
- Reassembles the processed-mode accumulators or forwards raw payload words.
- Reports per-packet status and error counters to the debug/control logic.

Parameters:
- RAW_WORDS, 512: payload beats per packet in raw mode (one beat per odd sensor index).
- TIMEOUT_CYCLES, 4096: maximum idle cycles between beats inside a packet before the packet is aborted.
- CNT_W, 16: width of the packet and error counters.

Ports:
- master_clock  in  1  single clock, 40 MHz domain.
- reset  in  1  synchronous, active-high reset.
- send_raw_data  in  1  expected payload mode; 1 = raw, 0 = processed (3 words). Sampled on header acceptance.
- data_tdata  in  32  AXIS slave data.
- data_tvalid  in  1  AXIS slave valid.
- data_tlast  in  1  AXIS slave last.
- data_tready  out  1  AXIS slave ready.
- raw_word  out  32  raw payload word.
- raw_index  out  9  payload beat index, 0..RAW_WORDS-1.
- raw_valid  out  1  one-cycle strobe per raw payload beat.
- res_timestamp  out  32  timestamp of the last good packet.
- res_c_acc  out  48  reassembled c accumulator.
- res_d_acc  out  48  reassembled d accumulator.
- res_valid  out  1  result held valid until res_ready.
- res_ready  in  1  result consumer ready.
- burst_done  out  1  one-cycle pulse on an accepted BBBBBBBB word with tlast=1.
- packet_count  out  CNT_W  good packets received; wraps.
- error_count  out  CNT_W  framing errors; saturates at all-ones.
- dbg_state  out  4  current FSM state.

Behaviour:
- Reset values: all outputs 0; FSM in HUNT; data_tready 1.
- Beat acceptance: a beat is accepted when data_tvalid && data_tready.
- data_tready = !(res_valid && !res_ready). It depends only on registered state.
- FSM states: HUNT=0, TIME_STAMP=1, PAYLOAD=2, FOOTER=3, POST=4.
  - HUNT: accepted AAAAAAAA -> TIME_STAMP, latching the mode. Any other word is discarded silently; no error is counted.
  - TIME_STAMP: accepted word is latched as the timestamp -> PAYLOAD. The beat counter is cleared.
  - PAYLOAD, processed mode: beats 0,1,2 are the 96-bit word {d_acc, c_acc}, least-significant word first.
    - c_acc = {w1[15:0], w0}.
    - d_acc = {w2, w1[31:16]}.
    - After beat 2 -> FOOTER.
  - PAYLOAD, raw mode: each beat produces raw_valid for one cycle with raw_index equal to the beat count. After beat RAW_WORDS-1 -> FOOTER.
  - FOOTER: 55555555 is a good packet.
    - packet_count increments.
    - In processed mode, res_* are loaded and res_valid is set. A new load overwrites a pending result only if res_ready was 1 the same cycle.
    - Then -> POST.
    - Any other word counts an error -> HUNT.
  - POST: AAAAAAAA -> TIME_STAMP (next packet). BBBBBBBB with tlast=1 -> burst_done, then HUNT. Any other word, or BBBBBBBB without tlast -> error, then HUNT.
- Mid-packet errors:
  - tlast=1 on any beat before FOOTER counts an error -> HUNT.
  - AAAAAAAA in PAYLOAD is treated as payload, not as a resync.
- Timeout: an idle counter runs in TIME_STAMP, PAYLOAD and FOOTER. It clears on each accepted beat. When it reaches TIMEOUT_CYCLES: error, -> HUNT.
- Handshake: res_valid clears when res_ready=1.
- Reset mid-packet: the FSM returns to HUNT and all counters and results clear. The remainder of the in-flight packet is discarded without error until the next header.
- Simultaneous error increment and clear: reset wins.

Optional Feature:
- Macro: TIMESTAMP_CHECK_EN.
- Defined: on each header-to-timestamp step, the new timestamp must be strictly greater than the previous good one; the first packet after reset is exempt. A violation counts an error, but the packet is still parsed and reported. The time-stamp check also compiles a `ts_error` out-port (1 bit, sticky until reset).
- Undefined: no comparison, no port, no extra registers.

Decomposition:
- Package axis_packet_pkg holds:
  - HEADER_VALUE, FOOTER_VALUE, TLAST_VALUE.
  - State enumeration.
  - PROC_WORDS=3.
- One sub-module, axis_pkt_err_counter: saturating counter with synchronous clear, used for error_count.

Test Plan:
- Processed packet AAAAAAAA, 00000010, 89ABCDEF, 4567_0123, 0011_2233, 55555555, then BBBBBBBB with tlast -> res_c_acc=012389ABCDEF, res_d_acc=001122334567, res_timestamp=10, packet_count=1, burst_done pulse.
- Raw mode, 512 payload words equal to i -> 512 raw_valid strobes with raw_index=i and raw_word=i; packet_count=1; error_count=0.
- Footer replaced by 12345678 -> error_count=1; FSM in HUNT; the following valid packet still parses.
- tvalid drops for TIMEOUT_CYCLES after the timestamp -> error_count=1; the next header is accepted.
- res_ready held 0 after the footer -> data_tready=0 until res_ready pulses; no beats lost.
- With TIMESTAMP_CHECK_EN, two packets with timestamps 20 then 15 -> error_count=1, ts_error=1, packet_count=2.
